// File: rtl/proc_io_pkg.sv
// Shared constants and helpers for the SAPHO processor I/O stream peripheral.
package proc_io_pkg;

    localparam int NUBITS_D = 32;
    localparam int FDEPTH_D = 8;
    localparam int NUIOOU_D = 2;
    localparam int ITRLVL_D = 4;

    // Fill count needs one extra bit so that "full" (== depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/proc_io_sfifo.sv
// First-word-fall-through input FIFO with fill count and a hold register that
// keeps the last consumed word visible while the FIFO is empty.
module proc_io_sfifo
    import proc_io_pkg::*;
#(
    parameter int NUBITS = NUBITS_D,
    parameter int FDEPTH = FDEPTH_D,
    localparam int CW    = cnt_width(FDEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_req,
    output logic [NUBITS-1:0] o_head,
    output logic              o_udf,
    output logic [CW-1:0]     o_cnt_next
);

    localparam int AW = $clog2(FDEPTH);

    logic [NUBITS-1:0] r_mem [FDEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_cnt;
    logic [NUBITS-1:0] r_hold;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_cnt_next;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(FDEPTH));
    assign w_push  = i_valid & ~w_full;
    assign w_pop   = i_req & ~w_empty;

    // NOTE: the default assignment first means every path drives w_cnt_next, so no latch is inferred.
    always_comb begin
        w_cnt_next = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_next = r_cnt + CW'(1);
            2'b01:   w_cnt_next = r_cnt - CW'(1);
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_hold   <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_hold   <= r_mem[r_rd_ptr];
            end
        end
    end

    // NOTE: storage is not reset; a zero count makes stale entries unreachable and io_in falls back to r_hold.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_ready    = ~w_full;
    assign o_head     = w_empty ? r_hold : r_mem[r_rd_ptr];
    assign o_udf      = i_req & w_empty;
    assign o_cnt_next = w_cnt_next;

endmodule

// File: rtl/proc_io_stream.sv
// Peripheral partner of a SAPHO processor I/O port: input FIFO, output channel
// registers with valid/ready drain, sticky error flags. Macro: PROC_IO_ITR_EN enables itr.
module proc_io_stream
    import proc_io_pkg::*;
#(
    parameter int NUBITS = NUBITS_D,
    parameter int NUIOOU = NUIOOU_D,
    parameter int FDEPTH = FDEPTH_D,
    parameter int ITRLVL = ITRLVL_D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUBITS-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [NUBITS-1:0]        io_in,
    input  logic                     req_in,
    input  logic [NUBITS-1:0]        io_out,
    input  logic [NUIOOU-1:0]        out_en,
    output logic [NUBITS*NUIOOU-1:0] m_data,
    output logic [NUIOOU-1:0]        m_valid,
    input  logic [NUIOOU-1:0]        m_ready,
    output logic                     itr,
    output logic                     err_udf,
    output logic                     err_ovf
);

    localparam int CW = cnt_width(FDEPTH);

    logic [CW-1:0] w_cnt_next;
    logic          w_udf;

    proc_io_sfifo #(
        .NUBITS (NUBITS),
        .FDEPTH (FDEPTH)
    ) u_sfifo (
        .clk        (clk),
        .rst        (rst),
        .i_data     (s_data),
        .i_valid    (s_valid),
        .o_ready    (s_ready),
        .i_req      (req_in),
        .o_head     (io_in),
        .o_udf      (w_udf),
        .o_cnt_next (w_cnt_next)
    );

    logic [NUBITS*NUIOOU-1:0] r_m_data;
    logic [NUIOOU-1:0]        r_m_valid;
    logic                     r_err_udf;
    logic                     r_err_ovf;

    // A write with a simultaneous drain is a clean hand-over, not an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_data  <= '0;
            r_m_valid <= '0;
            r_err_udf <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_udf) r_err_udf <= 1'b1;
            for (int k = 0; k < NUIOOU; k++) begin
                if (out_en[k]) begin
                    r_m_data[k*NUBITS +: NUBITS] <= io_out;
                    r_m_valid[k]                 <= 1'b1;
                    if (r_m_valid[k] && !m_ready[k]) r_err_ovf <= 1'b1;
                end else if (m_ready[k]) begin
                    r_m_valid[k] <= 1'b0;
                end
            end
        end
    end

    assign m_data  = r_m_data;
    assign m_valid = r_m_valid;
    assign err_udf = r_err_udf;
    assign err_ovf = r_err_ovf;

`ifdef PROC_IO_ITR_EN
    logic r_itr;

    always_ff @(posedge clk) begin
        if (rst) r_itr <= 1'b0;
        else     r_itr <= (w_cnt_next >= CW'(ITRLVL));
    end

    assign itr = r_itr;
`else
    logic w_unused_itr;

    assign w_unused_itr = (^w_cnt_next) ^ (ITRLVL > 0);
    assign itr          = 1'b0;
`endif

endmodule

// File: tb/tb_proc_io_stream.sv
// Self-checking bench for proc_io_stream: directed vector table followed by
// randomized traffic compared against a queue-based reference model.
module tb_proc_io_stream;

    localparam int NUBITS = 32;
    localparam int NUIOOU = 2;
    localparam int FDEPTH = 8;
    localparam int ITRLVL = 4;
`ifdef PROC_IO_ITR_EN
    localparam bit ITR_EN = 1'b1;
`else
    localparam bit ITR_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [NUBITS-1:0]        s_data = '0;
    logic                     s_valid = 1'b0;
    logic                     s_ready;
    logic [NUBITS-1:0]        io_in;
    logic                     req_in = 1'b0;
    logic [NUBITS-1:0]        io_out = '0;
    logic [NUIOOU-1:0]        out_en = '0;
    logic [NUBITS*NUIOOU-1:0] m_data;
    logic [NUIOOU-1:0]        m_valid;
    logic [NUIOOU-1:0]        m_ready = '0;
    logic                     itr;
    logic                     err_udf;
    logic                     err_ovf;

    always #5 clk = ~clk;

    proc_io_stream #(
        .NUBITS (NUBITS),
        .NUIOOU (NUIOOU),
        .FDEPTH (FDEPTH),
        .ITRLVL (ITRLVL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .io_in   (io_in),
        .req_in  (req_in),
        .io_out  (io_out),
        .out_en  (out_en),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .itr     (itr),
        .err_udf (err_udf),
        .err_ovf (err_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue, channels are plain valid/data pairs.
    logic [NUBITS-1:0]        mq[$];
    logic [NUBITS-1:0]        m_last;
    logic [NUIOOU-1:0]        mm_valid;
    logic [NUBITS*NUIOOU-1:0] mm_data;
    logic                     mm_udf;
    logic                     mm_ovf;
    logic                     mm_itr;

    task automatic model_step();
        if (rst) begin
            mq.delete();
            m_last   = '0;
            mm_valid = '0;
            mm_data  = '0;
            mm_udf   = 1'b0;
            mm_ovf   = 1'b0;
            mm_itr   = 1'b0;
        end else begin
            bit do_push;
            do_push = s_valid && (mq.size() < FDEPTH);
            if (req_in) begin
                if (mq.size() == 0) mm_udf = 1'b1;
                else                m_last = mq.pop_front();
            end
            if (do_push) mq.push_back(s_data);
            for (int k = 0; k < NUIOOU; k++) begin
                if (out_en[k]) begin
                    if (mm_valid[k] && !m_ready[k]) mm_ovf = 1'b1;
                    mm_data[k*NUBITS +: NUBITS] = io_out;
                    mm_valid[k] = 1'b1;
                end else if (m_ready[k]) begin
                    mm_valid[k] = 1'b0;
                end
            end
            mm_itr = (mq.size() >= ITRLVL);
        end
    endtask

    // One clock: model consumes the inputs held across the edge, outputs sampled 1 time unit later.
    task automatic run_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic              rst;
        logic              s_valid;
        logic [NUBITS-1:0] s_data;
        logic              req;
        logic [NUBITS-1:0] io_out;
        logic [1:0]        out_en;
        logic [1:0]        m_ready;
        logic              x_s_ready;
        logic [NUBITS-1:0] x_io_in;
        logic [1:0]        x_m_valid;
        logic [63:0]       x_m_data;
        logic              x_udf;
        logic              x_ovf;
        logic              x_itr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic sv, input logic [31:0] sd, input logic rq,
                       input logic [31:0] io, input logic [1:0] oe, input logic [1:0] mr,
                       input logic sr, input logic [31:0] xi, input logic [1:0] mv,
                       input logic [63:0] md, input logic u, input logic o, input logic it);
        vec_t v;
        v.rst = r;  v.s_valid = sv; v.s_data = sd; v.req = rq; v.io_out = io;
        v.out_en = oe; v.m_ready = mr; v.x_s_ready = sr; v.x_io_in = xi;
        v.x_m_valid = mv; v.x_m_data = md; v.x_udf = u; v.x_ovf = o; v.x_itr = it;
        vecs.push_back(v);
    endtask

    initial begin
        // Reset, then fill 0x1..0x8; a 9th push while full is refused.
        add(1, 0, 0, 0, 0, 2'b00, 2'b00,  1, 0, 2'b00, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            add(0, 1, i, 0, 0, 2'b00, 2'b00,  (i < 8), 1, 2'b00, 0, 0, 0, (i >= 4));
        add(0, 1, 'h99, 0, 0, 2'b00, 2'b00,  0, 1, 2'b00, 0, 0, 0, 1);
        // Three pops, then push 0x9 with a pop in the same cycle.
        add(0, 0, 0, 1, 0, 2'b00, 2'b00,  1, 2, 2'b00, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 2'b00, 2'b00,  1, 3, 2'b00, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 2'b00, 2'b00,  1, 4, 2'b00, 0, 0, 0, 1);
        add(0, 1, 9, 1, 0, 2'b00, 2'b00,  1, 5, 2'b00, 0, 0, 0, 1);
        // Drain to empty: itr drops when the count goes from 4 to 3.
        add(0, 0, 0, 1, 0, 2'b00, 2'b00,  1, 6, 2'b00, 0, 0, 0, 1);
        add(0, 0, 0, 1, 0, 2'b00, 2'b00,  1, 7, 2'b00, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 2'b00, 2'b00,  1, 8, 2'b00, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 2'b00, 2'b00,  1, 9, 2'b00, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 2'b00, 2'b00,  1, 9, 2'b00, 0, 0, 0, 0);
        // Read while empty holds the last word; a simultaneous push is still taken.
        add(0, 0, 0, 1, 0, 2'b00, 2'b00,  1, 9, 2'b00, 0, 1, 0, 0);
        add(0, 1, 'hA, 1, 0, 2'b00, 2'b00,  1, 'hA, 2'b00, 0, 1, 0, 0);
        // Output write, then overwrite while not ready.
        add(0, 0, 0, 0, 'hDEADBEEF, 2'b01, 2'b00,  1, 'hA, 2'b01, 64'hDEADBEEF, 1, 0, 0);
        add(0, 0, 0, 0, 'hCAFE0001, 2'b01, 2'b00,  1, 'hA, 2'b01, 64'hCAFE0001, 1, 1, 0);
        // Reset mid-operation clears FIFO, channels and sticky flags.
        add(1, 0, 0, 0, 0, 2'b00, 2'b00,  1, 0, 2'b00, 0, 0, 0, 0);
        add(0, 0, 0, 0, 'hDEADBEEF, 2'b01, 2'b00,  1, 0, 2'b01, 64'hDEADBEEF, 0, 0, 0);
        add(0, 0, 0, 0, 'hCAFE0001, 2'b01, 2'b01,  1, 0, 2'b01, 64'hCAFE0001, 0, 0, 0);
        add(0, 0, 0, 0, 0, 2'b00, 2'b01,  1, 0, 2'b00, 64'hCAFE0001, 0, 0, 0);
        // Both channels capture the same word, then drain independently.
        add(0, 0, 0, 0, 'h12345678, 2'b11, 2'b00,  1, 0, 2'b11, 64'h12345678_12345678, 0, 0, 0);
        add(0, 0, 0, 0, 0, 2'b00, 2'b10,  1, 0, 2'b01, 64'h12345678_12345678, 0, 0, 0);
        add(0, 0, 0, 0, 0, 2'b00, 2'b01,  1, 0, 2'b00, 64'h12345678_12345678, 0, 0, 0);
        // Channel 1 overflow; readiness of channel 0 must not mask it.
        add(0, 0, 0, 0, 'hAAAA5555, 2'b10, 2'b00,  1, 0, 2'b10, 64'hAAAA5555_12345678, 0, 0, 0);
        add(0, 0, 0, 0, 'h5555AAAA, 2'b10, 2'b01,  1, 0, 2'b10, 64'h5555AAAA_12345678, 0, 1, 0);

        #1;
        foreach (vecs[i]) begin
            rst     = vecs[i].rst;
            s_valid = vecs[i].s_valid;
            s_data  = vecs[i].s_data;
            req_in  = vecs[i].req;
            io_out  = vecs[i].io_out;
            out_en  = vecs[i].out_en;
            m_ready = vecs[i].m_ready;
            run_cycle();
            check($sformatf("v%0d s_ready", i), 64'(s_ready), 64'(vecs[i].x_s_ready));
            check($sformatf("v%0d io_in", i),   64'(io_in),   64'(vecs[i].x_io_in));
            check($sformatf("v%0d m_valid", i), 64'(m_valid), 64'(vecs[i].x_m_valid));
            check($sformatf("v%0d m_data", i),  64'(m_data),  vecs[i].x_m_data);
            check($sformatf("v%0d err_udf", i), 64'(err_udf), 64'(vecs[i].x_udf));
            check($sformatf("v%0d err_ovf", i), 64'(err_ovf), 64'(vecs[i].x_ovf));
            check($sformatf("v%0d itr", i),     64'(itr),     64'(ITR_EN ? vecs[i].x_itr : 1'b0));
        end

        // Randomized traffic against the reference model, starting from reset.
        rst = 1'b1; s_valid = 1'b0; req_in = 1'b0; out_en = '0; m_ready = '0;
        run_cycle();
        for (int c = 0; c < 2000; c++) begin
            rst     = ($urandom_range(0, 199) == 0);
            s_valid = ($urandom_range(0, 99) < 55);
            s_data  = $urandom;
            req_in  = ($urandom_range(0, 99) < 50);
            io_out  = $urandom;
            out_en  = 2'($urandom_range(0, 3));
            m_ready = 2'($urandom_range(0, 3));
            run_cycle();
            check($sformatf("r%0d s_ready", c), 64'(s_ready), 64'(mq.size() != FDEPTH));
            check($sformatf("r%0d io_in", c),   64'(io_in),   64'((mq.size() > 0) ? mq[0] : m_last));
            check($sformatf("r%0d m_valid", c), 64'(m_valid), 64'(mm_valid));
            check($sformatf("r%0d m_data", c),  64'(m_data),  64'(mm_data));
            check($sformatf("r%0d err_udf", c), 64'(err_udf), 64'(mm_udf));
            check($sformatf("r%0d err_ovf", c), 64'(err_ovf), 64'(mm_ovf));
            check($sformatf("r%0d itr", c),     64'(itr),     64'(ITR_EN ? mm_itr : 1'b0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
